// File: rtl/dff8r.sv
// dff8r: WIDTH-bit D register with asynchronous active-low reset.
// Delays d by exactly one clk cycle; q is driven straight from flops.
module dff8r #(
    parameter int unsigned            WIDTH       = 8,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Reset falling edge forces q without waiting for clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_dff8r.sv
// Self-checking bench for dff8r: directed scenarios plus a randomised
// run compared against a simple "last sampled byte or zero" model.
module tb_dff8r;

    localparam int unsigned WIDTH = 8;
    localparam logic [7:0]  RV    = 8'h00;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    int n_checks;
    int n_fail;

    dff8r #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        reset = 1'b1;
        d     = 8'hA5;
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (q !== RV) begin
            n_fail++;
            $display("FAIL reset_initial q=%h expected=%h", q, RV);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (q !== RV) begin
                n_fail++;
                $display("FAIL reset_hold_%0d q=%h expected=%h", i, q, RV);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (q !== RV) begin
            n_fail++;
            $display("FAIL reset_release_no_edge q=%h expected=%h", q, RV);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (q !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_first_load q=%h expected=%h", q, 8'hA5);
        end
    endtask

    task automatic test_capture();
        logic [7:0] vals [4];
        vals[0] = 8'h3C;
        vals[1] = 8'hFF;
        vals[2] = 8'h00;
        vals[3] = 8'h81;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d = vals[i];
            #1;
            n_checks++;
            if (i > 0 && q !== vals[i-1]) begin
                n_fail++;
                $display("FAIL capture_no_comb_%0d q=%h expected=%h", i, q, vals[i-1]);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (q !== vals[i]) begin
                n_fail++;
                $display("FAIL capture_%0d q=%h expected=%h", i, q, vals[i]);
            end
        end
    endtask

    task automatic test_async_assert();
        @(negedge clk);
        d = 8'h5A;
        @(posedge clk);
        #1;
        n_checks++;
        if (q !== 8'h5A) begin
            n_fail++;
            $display("FAIL async_preload q=%h expected=%h", q, 8'h5A);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (q !== RV || clk !== 1'b0) begin
            n_fail++;
            $display("FAIL async_assert q=%h expected=%h clk=%b", q, RV, clk);
        end
    endtask

    task automatic test_hold_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d = (i % 2 == 0) ? 8'hF0 : 8'h0F;
            @(posedge clk);
            #1;
            n_checks++;
            if (q !== RV) begin
                n_fail++;
                $display("FAIL hold_reset_%0d q=%h expected=%h", i, q, RV);
            end
        end
        @(negedge clk);
        d     = 8'h77;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (q !== 8'h77) begin
            n_fail++;
            $display("FAIL hold_release q=%h expected=%h", q, 8'h77);
        end
    endtask

    task automatic test_random();
        logic [7:0] model;
        model = q;
        for (int i = 0; i < 400; i++) begin
            if (i % 2 == 0) begin
                @(posedge clk);
                model = reset ? d : RV;
            end else begin
                @(negedge clk);
            end
            #1;
            n_checks++;
            if (q !== model) begin
                n_fail++;
                $display("FAIL random_step_%0d q=%h expected=%h", i, q, model);
            end
            #1;
            d = 8'($urandom);
            if (reset && $urandom_range(15) == 0) begin
                reset = 1'b0;
                model = RV;
                #1;
                n_checks++;
                if (q !== model) begin
                    n_fail++;
                    $display("FAIL random_async_%0d q=%h expected=%h", i, q, model);
                end
            end else if (!reset && $urandom_range(1) == 0) begin
                reset = 1'b1;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        d        = '0;
        test_reset();
        test_capture();
        test_async_assert();
        test_hold_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
